// File: rtl/gate_arb_pkg.sv
// rtl/gate_arb_pkg.sv - shared types, side constants and width helper for the gate arbiter
package gate_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OPEN  = 2'd2
  } gate_state_e;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  function automatic int cnt_width(input int capacity);
    return $clog2(capacity + 1);
  endfunction

endpackage

// File: rtl/gate_arbiter_if.sv
// rtl/gate_arbiter_if.sv - gate request/grant, barrier and occupancy signals with master/slave views
interface gate_arbiter_if #(
  parameter int ID_W     = 7,
  parameter int CAPACITY = 8
) ();
  localparam int CNT_W = gate_arb_pkg::cnt_width(CAPACITY);

  logic             req_left;
  logic             req_right;
  logic [ID_W-1:0]  id_left;
  logic [ID_W-1:0]  id_right;
  logic             exit_pulse;
  logic             grant_left;
  logic             grant_right;
  logic             barrier_open;
  logic [ID_W-1:0]  barrier_id;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             err_exit;

  modport master (
    output req_left, req_right, id_left, id_right, exit_pulse,
    input  grant_left, grant_right, barrier_open, barrier_id, count, full, empty, err_exit
  );

  modport slave (
    input  req_left, req_right, id_left, id_right, exit_pulse,
    output grant_left, grant_right, barrier_open, barrier_id, count, full, empty, err_exit
  );
endinterface

// File: rtl/gate_rr_pick.sv
// rtl/gate_rr_pick.sv - one-hot two-way pick; GATE_ARB_RR_EN selects pointer tie-break, else left wins
module gate_rr_pick
  import gate_arb_pkg::*;
(
  input  logic       req_left,
  input  logic       req_right,
  input  logic       ptr,
  output logic [1:0] pick
);

  logic left_wins_tie;

`ifdef GATE_ARB_RR_EN
  assign left_wins_tie = (ptr == SIDE_LEFT);
`else
  logic unused_ptr;
  assign unused_ptr    = ptr;
  assign left_wins_tie = 1'b1;
`endif

  always_comb begin
    pick = 2'b00;
    if (req_left && (!req_right || left_wins_tie)) begin
      pick[SIDE_LEFT] = 1'b1;
    end else if (req_right) begin
      pick[SIDE_RIGHT] = 1'b1;
    end
  end

endmodule

// File: rtl/gate_arbiter.sv
// rtl/gate_arbiter.sv - shared-entrance arbiter: grant FSM, barrier timer, occupancy count
// GATE_ARB_RR_EN builds the round-robin pointer; without it the tie-break is fixed left priority.
module gate_arbiter
  import gate_arb_pkg::*;
#(
  parameter int CAPACITY    = 8,
  parameter int ID_W        = 7,
  parameter int OPEN_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  gate_arbiter_if.slave bus
);

  localparam int CNT_W = cnt_width(CAPACITY);
  localparam int OC_W  = $clog2(OPEN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(CAPACITY);

  gate_state_e      state_q, state_d;
  logic             side_q, side_d;
  logic [OC_W-1:0]  open_cnt_q, open_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ID_W-1:0]  barrier_id_q, barrier_id_d;
  logic             err_exit_q, err_exit_d;
  logic             ptr;
  logic [1:0]       pick;
  logic             full, empty, entry, leave;

  // Occupancy flags come from the registered count, so a same-cycle exit cannot open a full lot.
  assign full  = (count_q == CAP_CNT);
  assign empty = (count_q == '0);

  gate_rr_pick u_pick (
    .req_left  (bus.req_left),
    .req_right (bus.req_right),
    .ptr       (ptr),
    .pick      (pick)
  );

  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    open_cnt_d   = open_cnt_q;
    barrier_id_d = barrier_id_q;
    entry        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!full && (pick != 2'b00)) begin
          entry        = 1'b1;
          side_d       = pick[SIDE_RIGHT] ? SIDE_RIGHT : SIDE_LEFT;
          barrier_id_d = pick[SIDE_RIGHT] ? bus.id_right : bus.id_left;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        open_cnt_d = OC_W'(OPEN_CYCLES - 1);
        state_d    = OPEN;
      end
      OPEN: begin
        if (open_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          open_cnt_d = open_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    leave   = bus.exit_pulse && !empty;
    count_d = count_q;
    if (entry && !leave) begin
      count_d = count_q + 1'b1;
    end else if (!entry && leave) begin
      count_d = count_q - 1'b1;
    end
    err_exit_d = err_exit_q | (bus.exit_pulse & empty);
  end

`ifdef GATE_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer favours the side that did not win the latest grant.
  always_comb begin
    ptr_d = ptr_q;
    if (entry) begin
      ptr_d = ~side_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= SIDE_LEFT;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = SIDE_LEFT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      side_q       <= SIDE_LEFT;
      open_cnt_q   <= '0;
      count_q      <= '0;
      barrier_id_q <= '0;
      err_exit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      side_q       <= side_d;
      open_cnt_q   <= open_cnt_d;
      count_q      <= count_d;
      barrier_id_q <= barrier_id_d;
      err_exit_q   <= err_exit_d;
    end
  end

  assign bus.grant_left   = (state_q == GRANT) && (side_q == SIDE_LEFT);
  assign bus.grant_right  = (state_q == GRANT) && (side_q == SIDE_RIGHT);
  assign bus.barrier_open = (state_q == OPEN);
  assign bus.barrier_id   = barrier_id_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.err_exit     = err_exit_q;

endmodule

// File: doc/gate_arbiter.md
# gate_arbiter

Shared-entrance arbiter for the parking controller. It sits between the two gate channels (left and right) and the single barrier and ID register they share. It grants one gate at a time, latches the granted user ID onto the barrier datapath, and holds the barrier open for a fixed time. It also keeps the occupancy count, refusing entry when the lot is full and decrementing on exit.

## Interface
Parameters:
- CAPACITY, 8, total parking spaces; legal range 1..255
- ID_W, 7, user ID width
- OPEN_CYCLES, 4, barrier-open duration in clk cycles; legal range ≥1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_left  in  1  left gate entry request, level, held until grant
- req_right  in  1  right gate entry request, level, held until grant
- id_left  in  ID_W  left user ID, valid while req_left=1
- id_right  in  ID_W  right user ID, valid while req_right=1
- exit_pulse  in  1  one-cycle pulse per departing car
- grant_left  out  1  one-cycle grant to left gate
- grant_right  out  1  one-cycle grant to right gate
- barrier_open  out  1  barrier drive
- barrier_id  out  ID_W  ID of car currently admitted
- count  out  $clog2(CAPACITY+1)  occupied spaces
- full  out  1  count==CAPACITY
- empty  out  1  count==0
- err_exit  out  1  sticky; exit_pulse seen while empty

## Operation
- FSM states: IDLE, GRANT, OPEN.
- IDLE:
  - If !full and any request is present, pick a side, latch its ID into barrier_id, assert that side's grant, increment count, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: the grant is high for this single cycle. Load the open counter with OPEN_CYCLES-1 and go to OPEN.
- OPEN:
  - barrier_open=1.
  - Decrement the counter each cycle; at 0 go to IDLE.
  - Requests are ignored throughout OPEN.
- Arbitration:
  - A single requester wins.
  - When both request, the round-robin pointer decides. The pointer flips to the other side after every grant.
  - The pointer resets to left, so left wins the first tie.
- Requester handshake: a requester drops its req in the cycle after it sees its grant. A req still high when the FSM is back in IDLE is treated as a new request.
- Full: no grant is issued and requests stay pending. Service resumes in the first IDLE cycle with !full.
- Exit:
  - exit_pulse with count>0 decrements count.
  - exit_pulse with count==0 leaves count at 0 and sets err_exit.
  - err_exit clears only on rst.
- Simultaneous entry increment and exit decrement on the same edge leave count unchanged.
- The full check uses the registered count only. An exit in the same cycle does not enable entry until the next cycle.
- barrier_id holds its last value outside GRANT/OPEN.

## Timing
- Reset values: state IDLE, count 0, all grants 0, barrier_open 0, barrier_id 0, err_exit 0, pointer left.
- Consequent reset outputs: empty=1, full=0.
- A reset asserted mid-OPEN closes the barrier at the next edge.
- Entry sequence, with the request sampled in IDLE at cycle N:
  - Cycle N+1: grant high, barrier_id and count updated.
  - Cycles N+2 .. N+1+OPEN_CYCLES: barrier_open high.
  - Cycle N+2+OPEN_CYCLES: FSM back in IDLE.
  - Cycle N+3+OPEN_CYCLES: earliest next grant.
- Derived outputs: full and empty are decoded from the count register, so they track count with zero added latency.
- Grant rules: grant_left and grant_right are never high together, and no grant is ever issued while full=1.

## Configuration
- GATE_ARB_RR_EN defined: round-robin tie-break as described.
- GATE_ARB_RR_EN undefined:
  - Fixed priority, left always wins a tie.
  - The pointer register is not built.
  - All other behaviour is identical.

## Structure
- Package gate_arb_pkg holds:
  - the state encoding IDLE/GRANT/OPEN,
  - side constants SIDE_LEFT=0 and SIDE_RIGHT=1,
  - a helper function for the count width.
- Sub-module gate_rr_pick:
  - Combinational two-way pick from req_left, req_right and the pointer.
  - Outputs a one-hot pick.
  - Holds the GATE_ARB_RR_EN switch.
- The FSM, open counter, occupancy counter and ID latch live in gate_arbiter.

## Test plan
- **Single request:** rst, then req_left=1, id_left=7'h15 → grant_left one cycle later, barrier_id=15h, count=1, barrier_open high for exactly 4 cycles.
- **Tie-break:** both requests held → grants alternate left, right, left. With GATE_ARB_RR_EN undefined, left is granted twice in a row and right gets no grant while req_left is held.
- **Fill to capacity:** fill to CAPACITY=8 → full=1, a further req_right gets no grant. One exit_pulse → count=7, and the grant arrives no earlier than 2 cycles after the exit.
- **Entry and exit on the same edge:** exit_pulse on the edge that enters GRANT with count=3 → count stays 3.
- **Exit while empty:** exit_pulse with count=0 → count=0, err_exit=1, which persists until rst.
- **Reset mid-OPEN:** rst asserted during OPEN → barrier_open=0 and count=0 next cycle, and left wins the next tie.
